dispense_out_ctrl: RTL and testbench
====================================

Name: dispense_out_ctrl

Overview:
- Output control stage directly downstream of the vending main FSM.
- Captures the one-cycle dispense event (item id + change amount).
- Hands the item to the item motor interface, then pays the change as a greedy sequence of coin requests to the coin hopper.
- Both external interfaces use req/ack handshakes; the block reports completion, shortfall and overrun.

Parameters:
- DENOM_HI, 100, largest coin value (8-bit units).
- DENOM_MID, 20, middle coin value.
- DENOM_LO, 5, smallest coin value. Required: DENOM_HI > DENOM_MID > DENOM_LO > 0.
- TIMEOUT_CYCLES, 1024, ack watchdog limit. Used only with ACK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- item_dispense_valid  in  1  one-cycle dispense event from main FSM.
- item_dispense  in  10  item id, sampled with valid.
- currency_change  in  8  change owed, sampled with valid.
- busy  out  1  high from capture until done.
- item_out_valid  out  1  item request to motor interface.
- item_out  out  10  latched item id.
- item_out_ack  in  1  motor accepts item.
- coin_req  out  1  coin request to hopper.
- coin_sel  out  2  coin code: 0=LO, 1=MID, 2=HI.
- coin_ack  in  1  hopper ejected one coin.
- done  out  1  one-cycle transaction-complete pulse.
- change_short  out  8  undispensable remainder, valid with done, held until next capture.
- overrun  out  1  sticky: event arrived while busy.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-low (rstn sampled on the rising clk edge).
- Reset values: all outputs 0; state IDLE; internal remaining=0.
- Reset asserted mid-transaction aborts immediately. No done pulse; coin_req and item_out_valid are low the next cycle.
- States: IDLE, ITEM, COIN, DONE.
- IDLE:
  - On item_dispense_valid, latch id into item_out and currency_change into remaining.
  - Clear change_short; go to ITEM.
  - item_out_valid rises the cycle after valid (latency 1).
- ITEM:
  - Hold item_out_valid and item_out stable until a cycle with item_out_ack=1.
  - Drop valid in the following cycle.
  - Then go to COIN if remaining >= DENOM_LO, else DONE.
- COIN:
  - coin_sel is the largest denomination <= remaining.
  - coin_req is held with coin_sel stable until coin_ack.
  - On the ack cycle, remaining -= selected value and coin_req drops for at least one cycle.
  - Next cycle: re-evaluate and stay in COIN if remaining >= DENOM_LO, else DONE.
- DONE:
  - done=1 for one cycle; change_short=remaining; busy drops; return to IDLE.
- Acks: an ack while the matching request is low is ignored.
- Arithmetic: 8-bit unsigned. Remaining never underflows, because selection guarantees value <= remaining.
- Zero change: sequence is ITEM -> DONE, with no coin_req.
- New event while busy: the event is dropped and overrun is set. overrun stays high until reset.
- An event in the same cycle as done is also treated as overrun. A new capture is accepted only in IDLE.

Optional Feature:
- Macro ACK_TIMEOUT_EN.
- When defined:
  - A counter runs while item_out_valid or coin_req is high awaiting ack.
  - When it reaches TIMEOUT_CYCLES, the request drops and the state goes to DONE.
  - change_short = full remaining (an item timeout also reports the latched change).
  - Extra output ack_timeout (1 bit) pulses with that done.
  - The counter clears on every ack and on each new request.
- When undefined: no counter, no ack_timeout port; the block waits indefinitely.

Decomposition:
- Package dispense_out_pkg holds:
  - the state encoding (IDLE/ITEM/COIN/DONE, 2-bit);
  - the coin_sel codes COIN_LO/COIN_MID/COIN_HI;
  - widths ITEM_W=10 and CASH_W=8.
- One sub-module, coin_picker:
  - combinational; input remaining and the denom parameters;
  - outputs coin_sel, coin_value, and has_coin (remaining >= DENOM_LO).
- The FSM and datapath stay in dispense_out_ctrl.

Test Plan:
- Item 0x123, change 0; ack item 2 cycles after valid -> item_out=0x123; no coin_req; done with change_short=0.
- Change 255, immediate acks -> coin_sel sequence HI,HI,MID,MID,LO,LO,LO; done; change_short=0.
- Change 37 -> MID,LO,LO,LO; done; change_short=2.
- Second event during COIN for change 100 -> overrun=1 and sticky; first transaction completes unchanged with a single HI coin.
- rstn low while coin_req high with change 60 -> next cycle all outputs 0, state IDLE, no done. A fresh event afterwards works normally.
- ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16, change 25, coin_ack never asserted -> coin_req drops after 16 cycles; done and ack_timeout pulse; change_short=25.

Source files
------------

// File: rtl/dispense_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dispense_out_pkg
// Purpose  : Shared widths, state encoding and coin codes for the dispense
//            output stage.
// Revision : 1.0 - initial release
// ============================================================================
package dispense_out_pkg;

  localparam int ITEM_W = 10;
  localparam int CASH_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITEM = 2'd1,
    COIN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] COIN_LO  = 2'd0;
  localparam logic [1:0] COIN_MID = 2'd1;
  localparam logic [1:0] COIN_HI  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/coin_picker.sv
`default_nettype none
// ============================================================================
// Module   : coin_picker
// Purpose  : Greedy coin selection: largest denomination not exceeding the
//            remaining change, plus a flag telling whether any coin fits.
// Revision : 1.0 - initial release
// ============================================================================
module coin_picker
  import dispense_out_pkg::*;
#(
  parameter int DENOM_HI  = 100,
  parameter int DENOM_MID = 20,
  parameter int DENOM_LO  = 5
) (
  input  logic [CASH_W-1:0] remaining,
  output logic [1:0]        coin_sel,
  output logic [CASH_W-1:0] coin_value,
  output logic              has_coin
);

  always_comb begin
    coin_sel   = COIN_LO;
    coin_value = CASH_W'(DENOM_LO);
    if (remaining >= CASH_W'(DENOM_HI)) begin
      coin_sel   = COIN_HI;
      coin_value = CASH_W'(DENOM_HI);
    end else if (remaining >= CASH_W'(DENOM_MID)) begin
      coin_sel   = COIN_MID;
      coin_value = CASH_W'(DENOM_MID);
    end
    has_coin = (remaining >= CASH_W'(DENOM_LO));
  end

endmodule
`default_nettype wire

// File: rtl/dispense_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dispense_out_ctrl
// Purpose  : Captures a dispense event, hands the item to the motor, then pays
//            change as greedy coin requests. Optional ack watchdog under the
//            ACK_TIMEOUT_EN macro (adds port ack_timeout).
// Revision : 1.0 - initial release
// ============================================================================
module dispense_out_ctrl
    import dispense_out_pkg::*;
#(
    parameter int DENOM_HI       = 100,
    parameter int DENOM_MID      = 20,
    parameter int DENOM_LO       = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              item_dispense_valid,
    input  logic [ITEM_W-1:0] item_dispense,
    input  logic [CASH_W-1:0] currency_change,
    output logic              busy,
    output logic              item_out_valid,
    output logic [ITEM_W-1:0] item_out,
    input  logic              item_out_ack,
    output logic              coin_req,
    output logic [1:0]        coin_sel,
    input  logic              coin_ack,
    output logic              done,
    output logic [CASH_W-1:0] change_short,
`ifdef ACK_TIMEOUT_EN
    output logic              ack_timeout,
`endif
    output logic              overrun
);

    state_t            r_state;
    logic [CASH_W-1:0] r_remaining;
    logic [1:0]        w_sel;
    logic [CASH_W-1:0] w_value;
    logic              w_has_coin;

`ifdef ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_wait_cnt;
`endif

    coin_picker #(
        .DENOM_HI  (DENOM_HI),
        .DENOM_MID (DENOM_MID),
        .DENOM_LO  (DENOM_LO)
    ) u_coin_picker (
        .remaining  (r_remaining),
        .coin_sel   (w_sel),
        .coin_value (w_value),
        .has_coin   (w_has_coin)
    );

    // done is raised on the edge that enters DONE, so the DONE cycle is the
    // pulse cycle; an event arriving then is not in IDLE and counts as overrun.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= IDLE;
            r_remaining    <= '0;
            busy           <= 1'b0;
            item_out_valid <= 1'b0;
            item_out       <= '0;
            coin_req       <= 1'b0;
            coin_sel       <= COIN_LO;
            done           <= 1'b0;
            change_short   <= '0;
            overrun        <= 1'b0;
`ifdef ACK_TIMEOUT_EN
            ack_timeout    <= 1'b0;
            r_wait_cnt     <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef ACK_TIMEOUT_EN
            ack_timeout <= 1'b0;
`endif
            if (item_dispense_valid && (r_state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (item_dispense_valid) begin
                        item_out       <= item_dispense;
                        r_remaining    <= currency_change;
                        change_short   <= '0;
                        item_out_valid <= 1'b1;
                        busy           <= 1'b1;
                        r_state        <= ITEM;
`ifdef ACK_TIMEOUT_EN
                        r_wait_cnt     <= '0;
`endif
                    end
                end

                ITEM: begin
                    if (item_out_ack) begin
                        item_out_valid <= 1'b0;
`ifdef ACK_TIMEOUT_EN
                        r_wait_cnt     <= '0;
`endif
                        if (w_has_coin) begin
                            r_state <= COIN;
                        end else begin
                            r_state      <= DONE;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            change_short <= r_remaining;
                        end
                    end
`ifdef ACK_TIMEOUT_EN
                    else if (r_wait_cnt == C_CNT_LAST) begin
                        item_out_valid <= 1'b0;
                        r_state        <= DONE;
                        done           <= 1'b1;
                        ack_timeout    <= 1'b1;
                        busy           <= 1'b0;
                        change_short   <= r_remaining;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end

                COIN: begin
                    if (!coin_req) begin
                        // Request phase: always at least one idle cycle after each ack.
                        if (w_has_coin) begin
                            coin_req <= 1'b1;
                            coin_sel <= w_sel;
`ifdef ACK_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end else begin
                            r_state      <= DONE;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            change_short <= r_remaining;
                        end
                    end else if (coin_ack) begin
                        coin_req    <= 1'b0;
                        r_remaining <= r_remaining - w_value;
`ifdef ACK_TIMEOUT_EN
                        r_wait_cnt  <= '0;
`endif
                    end
`ifdef ACK_TIMEOUT_EN
                    else if (r_wait_cnt == C_CNT_LAST) begin
                        coin_req     <= 1'b0;
                        r_state      <= DONE;
                        done         <= 1'b1;
                        ack_timeout  <= 1'b1;
                        busy         <= 1'b0;
                        change_short <= r_remaining;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispense_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispense_out_ctrl
// Purpose  : Self-checking bench for dispense_out_ctrl (ACK_TIMEOUT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispense_out_ctrl;
    import dispense_out_pkg::*;

    localparam int C_HI  = 100;
    localparam int C_MID = 20;
    localparam int C_LO  = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic              item_dispense_valid;
    logic [ITEM_W-1:0] item_dispense;
    logic [CASH_W-1:0] currency_change;
    logic              busy;
    logic              item_out_valid;
    logic [ITEM_W-1:0] item_out;
    logic              item_out_ack;
    logic              coin_req;
    logic [1:0]        coin_sel;
    logic              coin_ack;
    logic              done;
    logic [CASH_W-1:0] change_short;
    logic              overrun;
`ifdef ACK_TIMEOUT_EN
    logic              ack_timeout;
`endif

    always #5 clk = ~clk;

    dispense_out_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .item_dispense_valid (item_dispense_valid),
        .item_dispense       (item_dispense),
        .currency_change     (currency_change),
        .busy                (busy),
        .item_out_valid      (item_out_valid),
        .item_out            (item_out),
        .item_out_ack        (item_out_ack),
        .coin_req            (coin_req),
        .coin_sel            (coin_sel),
        .coin_ack            (coin_ack),
        .done                (done),
        .change_short        (change_short),
`ifdef ACK_TIMEOUT_EN
        .ack_timeout         (ack_timeout),
`endif
        .overrun             (overrun)
    );

    typedef struct {
        logic [ITEM_W-1:0] id;
        logic [CASH_W-1:0] change;
        int                idly;
        int                cdly;
        int                exp_n;
        int                exp_sh;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int ovr_exp = 0;
    int exp_q[$];
    int got_q[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Greedy change-making by division: counts of each coin, then remainder.
    task automatic model(input int c, output int nco, output int sh);
        int rem;
        int n_hi;
        int n_mid;
        int n_lo;
        rem   = c;
        n_hi  = rem / C_HI;  rem = rem % C_HI;
        n_mid = rem / C_MID; rem = rem % C_MID;
        n_lo  = rem / C_LO;  rem = rem % C_LO;
        exp_q.delete();
        repeat (n_hi)  exp_q.push_back(int'(COIN_HI));
        repeat (n_mid) exp_q.push_back(int'(COIN_MID));
        repeat (n_lo)  exp_q.push_back(int'(COIN_LO));
        nco = n_hi + n_mid + n_lo;
        sh  = rem;
    endtask

    // inject: 0 none, 1 second event during first coin request, 2 event on done cycle
    task automatic do_txn(input logic [ITEM_W-1:0] id, input logic [CASH_W-1:0] ch,
                          input int idly, input int cdly, input int inject,
                          input int exp_n, input int exp_sh, input bit spur);
        bit         seen_done;
        logic [1:0] sel;
        item_dispense_valid = 1'b1;
        item_dispense       = id;
        currency_change     = ch;
        step();
        item_dispense_valid = 1'b0;
        item_dispense       = ITEM_W'($urandom);
        currency_change     = CASH_W'($urandom);
        check("item_valid_lat1", item_out_valid, 1);
        check("busy_high", busy, 1);
        check("item_out", item_out, id);
        check("short_cleared", change_short, 0);
        repeat (idly) begin
            step();
            check("item_hold", {item_out_valid, item_out}, {1'b1, id});
        end
        item_out_ack = 1'b1;
        step();
        item_out_ack = 1'b0;
        check("item_drop", item_out_valid, 0);
        got_q.delete();
        seen_done = 1'b0;
        for (int budget = 0; budget < 400 && !seen_done; budget++) begin
            if (done) begin
                seen_done = 1'b1;
            end else if (coin_req) begin
                got_q.push_back(int'(coin_sel));
                sel = coin_sel;
                if (inject == 1 && got_q.size() == 1) begin
                    item_dispense_valid = 1'b1;
                    item_dispense       = 10'h2BD;
                    currency_change     = 8'd50;
                    step();
                    item_dispense_valid = 1'b0;
                    ovr_exp = 1;
                    check("overrun_set", overrun, 1);
                    check("req_hold_ovr", {coin_req, coin_sel}, {1'b1, sel});
                end
                repeat (cdly) begin
                    step();
                    check("coin_hold", {coin_req, coin_sel}, {1'b1, sel});
                end
                coin_ack = 1'b1;
                step();
                coin_ack = 1'b0;
                check("coin_drop", coin_req, 0);
            end else begin
                if (spur) begin
                    coin_ack     = 1'($urandom % 2);
                    item_out_ack = 1'($urandom % 2);
                end
                step();
                coin_ack     = 1'b0;
                item_out_ack = 1'b0;
            end
        end
        check("done_seen", seen_done, 1);
        check("change_short", change_short, exp_sh);
        check("busy_low", busy, 0);
`ifdef ACK_TIMEOUT_EN
        check("no_timeout", ack_timeout, 0);
`endif
        check("ncoins", got_q.size(), exp_n);
        for (int i = 0; i < exp_q.size(); i++) begin
            check("coin_seq", (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        end
        if (inject == 2) begin
            item_dispense_valid = 1'b1;
            step();
            item_dispense_valid = 1'b0;
            ovr_exp = 1;
            check("ovr_at_done", overrun, 1);
            check("no_capture", item_out_valid, 0);
        end else begin
            step();
        end
        check("done_pulse", done, 0);
        check("overrun_state", overrun, ovr_exp);
    endtask

    task automatic wait_coin_req();
        for (int b = 0; b < 20 && !coin_req; b++) step();
        check("coin_req_wait", coin_req, 1);
    endtask

    initial begin
        int n;
        int sh;
        rstn = 1'b0;
        item_dispense_valid = 1'b0;
        item_dispense = '0;
        currency_change = '0;
        item_out_ack = 1'b0;
        coin_ack = 1'b0;

        vecs[0] = '{10'h123, 8'd0,   1, 0, 0, 0};
        vecs[1] = '{10'h2AA, 8'd255, 0, 0, 7, 0};
        vecs[2] = '{10'h015, 8'd37,  0, 1, 4, 2};
        vecs[3] = '{10'h3FF, 8'd4,   0, 0, 0, 4};
        vecs[4] = '{10'h001, 8'd5,   2, 2, 1, 0};
        vecs[5] = '{10'h000, 8'd120, 0, 3, 2, 0};

        repeat (3) step();
        check("rst_outputs", {busy, item_out_valid, item_out, coin_req, coin_sel, done,
                              change_short, overrun}, 0);
        rstn = 1'b1;
        step();
        item_out_ack = 1'b1;
        coin_ack     = 1'b1;
        step();
        item_out_ack = 1'b0;
        coin_ack     = 1'b0;
        check("idle_ack_ignored", {busy, item_out_valid, coin_req, done}, 0);

        foreach (vecs[i]) begin
            model(int'(vecs[i].change), n, sh);
            do_txn(vecs[i].id, vecs[i].change, vecs[i].idly, vecs[i].cdly, 0,
                   vecs[i].exp_n, vecs[i].exp_sh, 1'b0);
        end

        for (int k = 0; k < 40; k++) begin
            logic [CASH_W-1:0] ch;
            ch = CASH_W'($urandom_range(0, 255));
            model(int'(ch), n, sh);
            do_txn(ITEM_W'($urandom), ch, $urandom_range(0, 3), $urandom_range(0, 3), 0,
                   n, sh, 1'b1);
        end

        model(45, n, sh);
        do_txn(10'h0AB, 8'd45, 0, 0, 2, n, sh, 1'b0);
        model(5, n, sh);
        do_txn(10'h0AC, 8'd5, 0, 0, 0, n, sh, 1'b0);

        // Reset mid-coin aborts cleanly and clears the sticky overrun.
        item_dispense_valid = 1'b1;
        item_dispense       = 10'h155;
        currency_change     = 8'd60;
        step();
        item_dispense_valid = 1'b0;
        item_out_ack = 1'b1;
        step();
        item_out_ack = 1'b0;
        wait_coin_req();
        check("rst_sel_mid", coin_sel, COIN_MID);
        rstn = 1'b0;
        step();
        check("rst_abort", {busy, item_out_valid, item_out, coin_req, coin_sel, done,
                            change_short, overrun}, 0);
        rstn = 1'b1;
        ovr_exp = 0;
        repeat (3) begin
            step();
            check("rst_no_done", {done, busy, coin_req}, 0);
        end
        model(60, n, sh);
        do_txn(10'h156, 8'd60, 1, 1, 0, n, sh, 1'b0);

        model(100, n, sh);
        do_txn(10'h200, 8'd100, 0, 2, 1, 1, 0, 1'b0);
        model(30, n, sh);
        do_txn(10'h201, 8'd30, 0, 0, 0, n, sh, 1'b0);

`ifdef ACK_TIMEOUT_EN
        begin
            int hi_cnt;
            item_dispense_valid = 1'b1;
            item_dispense       = 10'h0F0;
            currency_change     = 8'd25;
            step();
            item_dispense_valid = 1'b0;
            item_out_ack = 1'b1;
            step();
            item_out_ack = 1'b0;
            wait_coin_req();
            hi_cnt = 0;
            while (coin_req && hi_cnt < 100) begin
                hi_cnt++;
                step();
            end
            check("timeout_len", hi_cnt, 16);
            check("timeout_done", {done, ack_timeout, busy}, 3'b110);
            check("timeout_short", change_short, 25);
            step();
            check("timeout_pulse", {done, ack_timeout}, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
